field_window_arbiter: RTL and testbench

FIELD_WINDOW_ARBITER -- requirements
Module: field_window_arbiter

---
 rtl/field_window_arbiter.sv | 133 +++++++++++++
 tb/tb_field_window_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/field_window_arbiter.sv
// Round-robin arbiter feeding one shared windowing unit, with a tag pipeline matching its latency.
// Define FWA_OVF_CNT_EN to build the saturating dropped-request counter behind ovf_count.
module field_window_arbiter #(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned FIELD_SIZE = 16,
  parameter int unsigned WIN_LAT    = 1
) (
  input  logic                        sys_clk,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*FIELD_SIZE-1:0] req_field,
  output logic                        win_valid,
  output logic [FIELD_SIZE-1:0]       win_field,
  input  logic                        win_found,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [N_REQ-1:0]            rsp_found,
  output logic [15:0]                 ovf_count
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]      slot_vld_q, slot_vld_d;
  logic [FIELD_SIZE-1:0] slot_fld_q [N_REQ];
  logic [IdxW-1:0]       last_q;
  logic                  win_vld_q;
  logic [FIELD_SIZE-1:0] win_fld_q;
  logic [IdxW-1:0]       win_idx_q;
  logic [WIN_LAT-1:0]    tag_vld_q;
  logic [IdxW-1:0]       tag_idx_q [WIN_LAT];
  logic [N_REQ-1:0]      rsp_vld_q, rsp_vld_d;
  logic [N_REQ-1:0]      rsp_fnd_q, rsp_fnd_d;

  logic [N_REQ-1:0] gnt;
  logic             gnt_any;
  logic [IdxW-1:0]  gnt_idx;
  logic [N_REQ-1:0] load;

  // Search pending slots starting just after the last grant.
  always_comb begin
    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    gnt      = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand     = (32'(last_q) + off) % N_REQ;
      cand_idx = cand[IdxW-1:0];
      if (!gnt_any && slot_vld_q[cand_idx]) begin
        gnt_any       = 1'b1;
        gnt_idx       = cand_idx;
        gnt[cand_idx] = 1'b1;
      end
    end
  end

  // A slot granted this edge is free, so a same-edge request refills it.
  assign load       = req_valid & (~slot_vld_q | gnt);
  assign slot_vld_d = (slot_vld_q & ~gnt) | req_valid;

  always_comb begin
    rsp_vld_d = '0;
    rsp_fnd_d = '0;
    if (tag_vld_q[WIN_LAT-1]) begin
      rsp_vld_d[tag_idx_q[WIN_LAT-1]] = 1'b1;
      rsp_fnd_d[tag_idx_q[WIN_LAT-1]] = win_found;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_vld_q <= '0;
      for (int i = 0; i < N_REQ; i++) slot_fld_q[i] <= '0;
      last_q    <= IdxW'(N_REQ - 1);
      win_vld_q <= 1'b0;
      win_fld_q <= '0;
      win_idx_q <= '0;
      tag_vld_q <= '0;
      for (int s = 0; s < WIN_LAT; s++) tag_idx_q[s] <= '0;
      rsp_vld_q <= '0;
      rsp_fnd_q <= '0;
    end else begin
      slot_vld_q <= slot_vld_d;
      for (int i = 0; i < N_REQ; i++) begin
        if (load[i]) slot_fld_q[i] <= req_field[i*FIELD_SIZE +: FIELD_SIZE];
      end
      win_vld_q <= gnt_any;
      if (gnt_any) begin
        win_fld_q <= slot_fld_q[gnt_idx];
        win_idx_q <= gnt_idx;
        last_q    <= gnt_idx;
      end
      tag_vld_q[0] <= win_vld_q;
      tag_idx_q[0] <= win_idx_q;
      for (int s = 1; s < WIN_LAT; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_idx_q[s] <= tag_idx_q[s-1];
      end
      rsp_vld_q <= rsp_vld_d;
      rsp_fnd_q <= rsp_fnd_d;
    end
  end

  assign win_valid = win_vld_q;
  assign win_field = win_fld_q;
  assign rsp_valid = rsp_vld_q;
  assign rsp_found = rsp_fnd_q;

`ifdef FWA_OVF_CNT_EN
  logic [N_REQ-1:0] drop;
  logic [16:0]      ovf_sum;
  logic [15:0]      ovf_q, ovf_d;

  assign drop = req_valid & slot_vld_q & ~gnt;

  always_comb begin
    ovf_sum = {1'b0, ovf_q};
    for (int i = 0; i < N_REQ; i++) ovf_sum = ovf_sum + 17'(drop[i]);
    ovf_d = ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) ovf_q <= '0;
    else          ovf_q <= ovf_d;
  end

  assign ovf_count = ovf_q;
`else
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_field_window_arbiter.sv
// Scoreboard bench for field_window_arbiter: expected issues/responses queued at stimulus time.
// The windowing unit is modelled as odd parity of the issued field, returned WL cycles later.
module tb_field_window_arbiter;

  localparam int NR = 2;
  localparam int FS = 16;
  localparam int WL = 2;

`ifdef FWA_OVF_CNT_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  logic             sys_clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*FS-1:0] req_field = '0;
  logic             win_valid;
  logic [FS-1:0]    win_field;
  logic             win_found;
  logic [NR-1:0]    rsp_valid;
  logic [NR-1:0]    rsp_found;
  logic [15:0]      ovf_count;

  always #5 sys_clk = ~sys_clk;

  field_window_arbiter #(
    .N_REQ      (NR),
    .FIELD_SIZE (FS),
    .WIN_LAT    (WL)
  ) u_dut (
    .sys_clk   (sys_clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_field (req_field),
    .win_valid (win_valid),
    .win_field (win_field),
    .win_found (win_found),
    .rsp_valid (rsp_valid),
    .rsp_found (rsp_found),
    .ovf_count (ovf_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int   idx;
    logic found;
  } rsp_t;

  logic [FS-1:0] exp_win [$];
  rsp_t          exp_rsp [$];

  // Windowing unit model; random noise on win_found outside its valid slot.
  logic [WL-1:0] wm_vld, wm_fnd;
  logic          noise;
  always @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      wm_vld <= '0;
      wm_fnd <= '0;
      noise  <= 1'b0;
    end else begin
      wm_vld <= {wm_vld[WL-2:0], win_valid};
      wm_fnd <= {wm_fnd[WL-2:0], ^win_field};
      noise  <= 1'($urandom);
    end
  end
  assign win_found = wm_vld[WL-1] ? wm_fnd[WL-1] : noise;

  logic [FS-1:0] mon_ef;
  rsp_t          mon_er;
  logic [NR-1:0] mon_ev;
  always @(negedge sys_clk) begin
    if (reset_n) begin
      if (win_valid) begin
        n_tests++;
        if (exp_win.size() == 0) begin
          n_fail++;
          $display("FAIL win_issue: unexpected win_valid with field %h, required none", win_field);
        end else begin
          mon_ef = exp_win.pop_front();
          if (win_field !== mon_ef) begin
            n_fail++;
            $display("FAIL win_issue: win_field got %h required %h", win_field, mon_ef);
          end
        end
      end
      if (rsp_valid !== '0) begin
        n_tests++;
        if (exp_rsp.size() == 0) begin
          n_fail++;
          $display("FAIL rsp: unexpected rsp_valid %b, required none", rsp_valid);
        end else begin
          mon_er = exp_rsp.pop_front();
          mon_ev = NR'(1) << mon_er.idx;
          if (rsp_valid !== mon_ev || (rsp_found & mon_ev) !== (mon_er.found ? mon_ev : '0)) begin
            n_fail++;
            $display("FAIL rsp: got valid %b found %b, required valid %b found %b",
                     rsp_valid, rsp_found, mon_ev, mon_er.found ? mon_ev : '0);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic expect_issue(input logic [FS-1:0] f, input int idx);
    rsp_t r;
    r.idx   = idx;
    r.found = ^f;
    exp_win.push_back(f);
    exp_rsp.push_back(r);
  endtask

  task automatic apply_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    exp_win.delete();
    exp_rsp.delete();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_drain(output int left);
    int cyc = 0;
    while ((exp_win.size() != 0 || exp_rsp.size() != 0) && cyc < 40) begin
      tick();
      cyc++;
    end
    tick();
    left = exp_win.size() + exp_rsp.size();
  endtask

  function automatic logic [FS-1:0] fair_field(input int i, input int e);
    return {4'(i + 1), 4'(e), 8'(e * 13 + 5)};
  endfunction

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    tick();
    tick();
    n_tests++;
    if (win_valid !== 1'b0 || win_field !== '0) begin
      n_fail++;
      $display("FAIL reset_win: got valid %b field %h, required 0 0000", win_valid, win_field);
    end
    n_tests++;
    if (rsp_valid !== '0 || rsp_found !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp: got valid %b found %b, required 00 00", rsp_valid, rsp_found);
    end
    n_tests++;
    if (ovf_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_ovf: got %h required 0000", ovf_count);
    end
    reset_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_single();
    int left;
    req_valid = 2'b01;
    req_field[FS-1:0] = 16'h1234;
    expect_issue(16'h1234, 0);
    tick();
    req_valid = '0;
    @(negedge sys_clk);
    n_tests++;
    if (win_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_latency: win_valid after first edge got %b required 0", win_valid);
    end
    @(negedge sys_clk);
    n_tests++;
    if (win_valid !== 1'b1 || win_field !== 16'h1234) begin
      n_fail++;
      $display("FAIL single_issue: got valid %b field %h required 1 1234", win_valid, win_field);
    end
    repeat (2) @(negedge sys_clk);
    n_tests++;
    if (rsp_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL single_rsp_early: rsp_valid got %b required 00", rsp_valid);
    end
    @(negedge sys_clk);
    n_tests++;
    if (rsp_valid !== 2'b01 || rsp_found[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_rsp: got valid %b found0 %b required 01 1", rsp_valid, rsp_found[0]);
    end
    wait_drain(left);
    n_tests++;
    if (left !== 0) begin
      n_fail++;
      $display("FAIL single_drain: %0d outstanding, required 0", left);
    end
    n_tests++;
    if (win_valid !== 1'b0 || win_field !== 16'h1234) begin
      n_fail++;
      $display("FAIL single_hold: got valid %b field %h required 0 1234", win_valid, win_field);
    end
  endtask

  task automatic test_simultaneous();
    int left;
    apply_reset();
    req_valid = 2'b11;
    req_field = {16'hBBBB, 16'hAAAA};
    expect_issue(16'hAAAA, 0);
    expect_issue(16'hBBBB, 1);
    tick();
    req_valid = '0;
    repeat (3) @(negedge sys_clk);
    n_tests++;
    if (win_valid !== 1'b1 || win_field !== 16'hBBBB) begin
      n_fail++;
      $display("FAIL simul_b2b: got valid %b field %h required 1 bbbb", win_valid, win_field);
    end
    wait_drain(left);
    n_tests++;
    if (left !== 0) begin
      n_fail++;
      $display("FAIL simul_drain: %0d outstanding, required 0", left);
    end
  endtask

  task automatic test_overflow();
    int left;
    apply_reset();
    req_valid = 2'b11;
    req_field = {16'h1111, 16'h0F0E};
    expect_issue(16'h0F0E, 0);
    expect_issue(16'h1111, 1);
    tick();
    req_valid = 2'b10;
    req_field = {16'h2222, 16'h0000};
    tick();
    req_valid = '0;
    n_tests++;
    if (ovf_count !== (OvfEn ? 16'd1 : 16'd0)) begin
      n_fail++;
      $display("FAIL ovf_count: got %0d required %0d", ovf_count, OvfEn ? 1 : 0);
    end
    wait_drain(left);
    n_tests++;
    if (left !== 0) begin
      n_fail++;
      $display("FAIL ovf_drain: %0d outstanding, required 0", left);
    end
    n_tests++;
    if (ovf_count !== (OvfEn ? 16'd1 : 16'd0)) begin
      n_fail++;
      $display("FAIL ovf_hold: got %0d required %0d", ovf_count, OvfEn ? 1 : 0);
    end
  endtask

  task automatic test_refill();
    int left;
    apply_reset();
    req_valid = 2'b01;
    req_field[FS-1:0] = 16'h0001;
    expect_issue(16'h0001, 0);
    expect_issue(16'h0002, 0);
    tick();
    req_field[FS-1:0] = 16'h0002;
    tick();
    req_valid = '0;
    repeat (2) @(negedge sys_clk);
    n_tests++;
    if (win_valid !== 1'b1 || win_field !== 16'h0002) begin
      n_fail++;
      $display("FAIL refill_issue: got valid %b field %h required 1 0002", win_valid, win_field);
    end
    wait_drain(left);
    n_tests++;
    if (left !== 0) begin
      n_fail++;
      $display("FAIL refill_drain: %0d outstanding, required 0", left);
    end
    n_tests++;
    if (ovf_count !== 16'h0) begin
      n_fail++;
      $display("FAIL refill_ovf: got %0d required 0", ovf_count);
    end
  endtask

  task automatic test_fairness();
    int left;
    apply_reset();
    // Grant k goes to (k-1)%2 carrying that requester's field from edge k-2 (edge 0 for k=1).
    for (int k = 1; k <= 21; k++) begin
      expect_issue(fair_field((k - 1) % 2, (k == 1) ? 0 : k - 2), (k - 1) % 2);
    end
    for (int e = 0; e < 20; e++) begin
      req_valid = 2'b11;
      req_field = {fair_field(1, e), fair_field(0, e)};
      tick();
    end
    req_valid = '0;
    wait_drain(left);
    n_tests++;
    if (left !== 0) begin
      n_fail++;
      $display("FAIL fair_drain: %0d outstanding, required 0", left);
    end
    n_tests++;
    if (ovf_count !== (OvfEn ? 16'd19 : 16'd0)) begin
      n_fail++;
      $display("FAIL fair_ovf: got %0d required %0d", ovf_count, OvfEn ? 19 : 0);
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    req_valid = 2'b01;
    req_field[FS-1:0] = 16'h5A5A;
    exp_win.push_back(16'h5A5A);
    tick();
    req_valid = '0;
    repeat (2) @(negedge sys_clk);
    n_tests++;
    if (win_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_issue: win_valid got %b required 1", win_valid);
    end
    @(posedge sys_clk);
    #1;
    reset_n = 1'b0;
    exp_win.delete();
    exp_rsp.delete();
    #1;
    n_tests++;
    if (win_valid !== 1'b0 || win_field !== '0 || rsp_valid !== '0 || rsp_found !== '0) begin
      n_fail++;
      $display("FAIL midrst_clear: got win %b/%h rsp %b/%b required all 0",
               win_valid, win_field, rsp_valid, rsp_found);
    end
    tick();
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge sys_clk);
      n_tests++;
      if (rsp_valid !== '0 || win_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_quiet: cycle %0d got rsp %b win %b required 00 0",
                 c, rsp_valid, win_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_overflow();
    test_refill();
    test_fairness();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
